// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter register and fetch-request controller.
// Holds the PC, drives the external adder (pc + PC_INC), issues fetch
// addresses with a valid/ready handshake, and applies stalls and redirects.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   stall              decode hazard; holds PC and masks the request
//   redirect_valid/    taken branch/jump and its destination
//   redirect_target
//   imem_ready         instruction memory accepts fetch_pc this cycle
//   adder_sum          next sequential PC from the external adder
//   adder_a/adder_b    adder operands (pc, PC_INC)
//   fetch_valid/       fetch request and address
//   fetch_pc
//   flush              one-cycle pulse after a redirect
//   misaligned         one-cycle pulse when the redirect target was not word aligned
//   fetch_count        accepted fetches, wraps modulo 2^32
module pc_fetch_unit #(
  parameter int unsigned             WIDTH        = 32,
  parameter logic [WIDTH-1:0]        RESET_VECTOR = '0,
  parameter int unsigned             PC_INC       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             imem_ready,
  input  logic [WIDTH-1:0] adder_sum,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  output logic             fetch_valid,
  output logic [WIDTH-1:0] fetch_pc,
  output logic             flush,
  output logic             misaligned,
  output logic [31:0]      fetch_count
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             flush_q, flush_d;
  logic             misaligned_q, misaligned_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept;

  // Datapath views of the PC register.
  assign adder_a     = pc_q;
  assign adder_b     = WIDTH'(PC_INC);
  assign fetch_pc    = pc_q;
  assign flush       = flush_q;
  assign misaligned  = misaligned_q;
  assign fetch_count = count_q;

  // Request only in FETCH; a stall masks it combinationally.
  assign fetch_valid = (state_q == ST_FETCH) && !stall;
  assign accept      = fetch_valid && imem_ready;

  // Next-state: a redirect overrides stall and accept in every state.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    flush_d      = 1'b0;
    misaligned_d = 1'b0;
    count_d      = count_q;

    if (redirect_valid) begin
      pc_d         = {redirect_target[WIDTH-1:2], 2'b00};
      state_d      = ST_REDIRECT;
      flush_d      = 1'b1;
      misaligned_d = |redirect_target[1:0];
    end else begin
      case (state_q)
        ST_BOOT:     state_d = ST_FETCH;
        ST_FETCH: begin
          if (accept) begin
            pc_d    = adder_sum;
            count_d = count_q + CNT_W'(1);
          end
        end
        ST_REDIRECT: state_d = ST_FETCH;
        default:     state_d = ST_BOOT;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_VECTOR;
      flush_q      <= 1'b0;
      misaligned_q <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      flush_q      <= flush_d;
      misaligned_q <= misaligned_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: expected fetch addresses are queued
// as stimulus is set up and popped by a monitor on every accepted fetch.
module tb_pc_fetch_unit;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             stall;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_target;
  logic             imem_ready;
  logic [WIDTH-1:0] adder_sum;
  logic [WIDTH-1:0] adder_a;
  logic [WIDTH-1:0] adder_b;
  logic             fetch_valid;
  logic [WIDTH-1:0] fetch_pc;
  logic             flush;
  logic             misaligned;
  logic [31:0]      fetch_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  pc_fetch_unit #(
    .WIDTH(WIDTH),
    .RESET_VECTOR(32'h0),
    .PC_INC(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .imem_ready(imem_ready),
    .adder_sum(adder_sum),
    .adder_a(adder_a),
    .adder_b(adder_b),
    .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc),
    .flush(flush),
    .misaligned(misaligned),
    .fetch_count(fetch_count)
  );

  // External 32-bit adder.
  assign adder_sum = adder_a + adder_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every fetch accepted at the coming edge (and not overridden
  // by a redirect) must match the next queued address.
  always @(negedge clk) begin
    if (rst_n && fetch_valid && imem_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_fetch", fetch_pc, 32'hDEAD_BEEF);
      end else begin
        check_eq("fetch_addr", fetch_pc, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    imem_ready      = 1'b1;
    repeat (2) tick();

    // Reset state
    check_eq("rst_valid", 32'(fetch_valid), 32'd0);
    check_eq("rst_pc", fetch_pc, 32'h0);
    check_eq("rst_flush", 32'(flush), 32'd0);
    check_eq("rst_mis", 32'(misaligned), 32'd0);
    check_eq("rst_count", fetch_count, 32'd0);
    check_eq("adder_b", adder_b, 32'd4);

    // Sequential fetch after BOOT
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    rst_n = 1'b1;
    #1;
    check_eq("boot_valid", 32'(fetch_valid), 32'd0);
    tick();
    check_eq("first_valid", 32'(fetch_valid), 32'd1);
    check_eq("first_pc", fetch_pc, 32'h0);
    repeat (4) tick();
    imem_ready = 1'b0;
    #1;
    check_eq("count_4", fetch_count, 32'd4);
    check_eq("pc_16", fetch_pc, 32'h10);
    check_eq("adder_a", adder_a, 32'h10);

    // Memory not ready: request held
    repeat (3) begin
      tick();
      check_eq("wait_pc", fetch_pc, 32'h10);
      check_eq("wait_valid", 32'(fetch_valid), 32'd1);
      check_eq("wait_count", fetch_count, 32'd4);
    end
    exp_q.push_back(32'h10);
    imem_ready = 1'b1;
    tick();

    // Stall two cycles at pc=20
    stall = 1'b1;
    #1;
    check_eq("stall_valid", 32'(fetch_valid), 32'd0);
    check_eq("stall_pc", fetch_pc, 32'h14);
    check_eq("stall_count", fetch_count, 32'd5);
    tick();
    check_eq("stall_pc2", fetch_pc, 32'h14);
    check_eq("stall_valid2", 32'(fetch_valid), 32'd0);
    exp_q.push_back(32'h14);
    exp_q.push_back(32'h18);
    stall = 1'b0;
    tick();
    tick();

    // Redirect while stalled -> flush, bubble, then target
    stall           = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h100;
    exp_q.push_back(32'h100);
    tick();
    stall          = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check_eq("redir_flush", 32'(flush), 32'd1);
    check_eq("redir_mis", 32'(misaligned), 32'd0);
    check_eq("redir_bubble", 32'(fetch_valid), 32'd0);
    check_eq("redir_pc", fetch_pc, 32'h100);
    check_eq("redir_count", fetch_count, 32'd7);
    tick();
    check_eq("post_flush", 32'(flush), 32'd0);
    check_eq("post_valid", 32'(fetch_valid), 32'd1);
    tick();
    check_eq("pc_104", fetch_pc, 32'h104);
    check_eq("count_8", fetch_count, 32'd8);

    // Misaligned redirect coinciding with an accept
    redirect_valid  = 1'b1;
    redirect_target = 32'h203;
    tick();
    redirect_valid = 1'b0;
    #1;
    check_eq("mis_pulse", 32'(misaligned), 32'd1);
    check_eq("mis_flush", 32'(flush), 32'd1);
    check_eq("mis_pc", fetch_pc, 32'h200);
    check_eq("mis_count", fetch_count, 32'd8);
    tick();
    check_eq("mis_clear", 32'(misaligned), 32'd0);
    check_eq("mis_fetch_pc", fetch_pc, 32'h200);

    // Back-to-back redirects: latest wins
    redirect_valid  = 1'b1;
    redirect_target = 32'h300;
    tick();
    redirect_target = 32'hFFFF_FFFC;
    #1;
    check_eq("b2b_flush1", 32'(flush), 32'd1);
    tick();
    redirect_valid = 1'b0;
    #1;
    check_eq("b2b_flush2", 32'(flush), 32'd1);
    check_eq("b2b_pc", fetch_pc, 32'hFFFF_FFFC);
    check_eq("b2b_bubble", 32'(fetch_valid), 32'd0);

    // Wrap-around
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    tick();
    check_eq("b2b_flush_end", 32'(flush), 32'd0);
    tick();
    check_eq("wrap_pc", fetch_pc, 32'h0);
    tick();
    imem_ready = 1'b0;
    #1;
    check_eq("wrap_count", fetch_count, 32'd10);

    // Asynchronous reset during a pending request at pc=0x40
    redirect_valid  = 1'b1;
    redirect_target = 32'h40;
    tick();
    redirect_valid = 1'b0;
    tick();
    check_eq("pend_valid", 32'(fetch_valid), 32'd1);
    check_eq("pend_pc", fetch_pc, 32'h40);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(fetch_valid), 32'd0);
    check_eq("arst_pc", fetch_pc, 32'h0);
    check_eq("arst_count", fetch_count, 32'd0);
    check_eq("arst_flush", 32'(flush), 32'd0);
    tick();
    rst_n      = 1'b1;
    imem_ready = 1'b1;
    #1;
    check_eq("reboot_valid", 32'(fetch_valid), 32'd0);
    exp_q.push_back(32'h0);
    tick();
    tick();
    imem_ready = 1'b0;
    #1;
    check_eq("reboot_pc", fetch_pc, 32'h4);
    check_eq("reboot_count", fetch_count, 32'd1);
    check_eq("sb_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
